// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared encodings for the instruction decoder: Op classes,
//                ALUControl codes, ImmSrc codes, DP cmd values, and the
//                bundled control-word type that the decoder registers.
//  Revision    : 1.0  initial release
// ============================================================================
package decoder_pkg;

    // Instruction class carried in instruction bits [27:26].
    typedef enum logic [1:0] {
        c_OP_DP     = 2'b00,
        c_OP_MEM    = 2'b01,
        c_OP_BRANCH = 2'b10,
        c_OP_UNSUP  = 2'b11
    } op_e;

    // ALU operation select.
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_ORR = 3'b011;
    localparam logic [2:0] c_ALU_EOR = 3'b100;

    // Immediate-extend select.
    localparam logic [1:0] c_IMM_DP     = 2'b00;
    localparam logic [1:0] c_IMM_MEM    = 2'b01;
    localparam logic [1:0] c_IMM_BRANCH = 2'b10;

    // Register-source select: bit1 reads Rd as second source, bit0 reads R15.
    localparam logic [1:0] c_REGSRC_NONE  = 2'b00;
    localparam logic [1:0] c_REGSRC_PC    = 2'b01;
    localparam logic [1:0] c_REGSRC_STORE = 2'b10;

    // Data-processing cmd field, Funct[4:1].
    localparam logic [3:0] c_CMD_AND = 4'b0000;
    localparam logic [3:0] c_CMD_EOR = 4'b0001;
    localparam logic [3:0] c_CMD_SUB = 4'b0010;
    localparam logic [3:0] c_CMD_ADD = 4'b0100;
    localparam logic [3:0] c_CMD_CMP = 4'b1010;
    localparam logic [3:0] c_CMD_ORR = 4'b1100;

    // Register index of the program counter.
    localparam logic [3:0] c_PC_REG = 4'd15;

    // Complete set of decoded controls, registered as one word.
    typedef struct packed {
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic       no_write;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] flag_w;
        logic [2:0] alu_control;
    } ctrl_t;

    // True when the destination register is the PC.
    function automatic logic is_pc_dest(input logic [3:0] rd);
        return (rd == c_PC_REG);
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_alu_dec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dec
//  Description : Combinational ALU-operation and flag-write decode for
//                data-processing instructions. Produces neutral values when
//                the instruction is not a data-processing op.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_dec
    import decoder_pkg::*;
(
    input  logic       i_alu_op,
    input  logic [3:0] i_cmd,
    input  logic       i_s,
    output logic [2:0] o_alu_control,
    output logic [1:0] o_flag_w,
    output logic       o_no_write
);

    logic [2:0] w_alu_control;
    logic [1:0] w_flag_w;
    logic       w_no_write;
    logic       w_is_cmp;
    logic       w_arith;

    // Map cmd to an ALU operation and derive which flag groups are written.
    always_comb begin
        w_alu_control = c_ALU_ADD;
        w_flag_w      = 2'b00;
        w_no_write    = 1'b0;
        w_is_cmp      = 1'b0;
        w_arith       = 1'b0;
        if (i_alu_op) begin
            case (i_cmd)
                c_CMD_ADD: w_alu_control = c_ALU_ADD;
                c_CMD_SUB: w_alu_control = c_ALU_SUB;
                c_CMD_AND: w_alu_control = c_ALU_AND;
                c_CMD_ORR: w_alu_control = c_ALU_ORR;
                c_CMD_EOR: w_alu_control = c_ALU_EOR;
                c_CMD_CMP: begin
                    w_alu_control = c_ALU_SUB;
                    w_is_cmp      = 1'b1;
                end
                default:   w_alu_control = c_ALU_ADD;
            endcase
            // Carry/overflow are only meaningful for add and subtract.
            w_arith    = (w_alu_control == c_ALU_ADD) || (w_alu_control == c_ALU_SUB);
            w_no_write = w_is_cmp;
            // CMP exists only to set flags, so it writes all of them even with S=0.
            if (w_is_cmp) begin
                w_flag_w = 2'b11;
            end else begin
                w_flag_w = {i_s, i_s & w_arith};
            end
        end
    end

    assign o_alu_control = w_alu_control;
    assign o_flag_w      = w_flag_w;
    assign o_no_write    = w_no_write;

endmodule : alu_dec
`default_nettype wire

// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
//  Module      : decoder
//  Description : Single-cycle instruction control decoder. Decodes Op, Funct
//                and Rd combinationally and registers every control output,
//                giving one cycle of latency. Asynchronous active-low reset
//                clears all outputs immediately.
//  Revision    : 1.0  initial release
// ============================================================================
module decoder
    import decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic       NoWrite,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] FlagW,
    output logic [2:0] ALUControl
);

    // Main-decode results ahead of the output register.
    logic       w_branch;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_mem_to_reg;
    logic       w_alu_src;
    logic       w_alu_op;
    logic [1:0] w_imm_src;
    logic [1:0] w_reg_src;

    // ALU decode results.
    logic [2:0] w_alu_control;
    logic [1:0] w_flag_w;
    logic       w_no_write;

    ctrl_t      w_ctrl_d;
    ctrl_t      r_ctrl_q;

    // Classify the instruction by Op and set the datapath steering controls.
    always_comb begin
        w_branch     = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = 1'b0;
        w_imm_src    = c_IMM_DP;
        w_reg_src    = c_REGSRC_NONE;
        case (op_e'(Op))
            c_OP_DP: begin
                w_reg_w   = 1'b1;
                w_alu_src = Funct[5];
                w_alu_op  = 1'b1;
            end
            c_OP_MEM: begin
                w_alu_src = 1'b1;
                w_imm_src = c_IMM_MEM;
                if (Funct[0]) begin
                    w_reg_w      = 1'b1;
                    w_mem_to_reg = 1'b1;
                end else begin
                    w_mem_w   = 1'b1;
                    w_reg_src = c_REGSRC_STORE;
                end
            end
            c_OP_BRANCH: begin
                // Condition field is not examined; every branch decodes as B.
                w_branch  = 1'b1;
                w_alu_src = 1'b1;
                w_imm_src = c_IMM_BRANCH;
                w_reg_src = c_REGSRC_PC;
            end
            default: begin
                // Unsupported class: leave every control deasserted.
            end
        endcase
    end

    alu_dec u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_cmd         (Funct[4:1]),
        .i_s           (Funct[0]),
        .o_alu_control (w_alu_control),
        .o_flag_w      (w_flag_w),
        .o_no_write    (w_no_write)
    );

    // Assemble the next control word; PCS uses the unregistered RegW/Branch.
    always_comb begin
        w_ctrl_d             = '0;
        w_ctrl_d.pcs         = (is_pc_dest(Rd) & w_reg_w) | w_branch;
        w_ctrl_d.reg_w       = w_reg_w;
        w_ctrl_d.mem_w       = w_mem_w;
        w_ctrl_d.mem_to_reg  = w_mem_to_reg;
        w_ctrl_d.alu_src     = w_alu_src;
        w_ctrl_d.no_write    = w_no_write;
        w_ctrl_d.imm_src     = w_imm_src;
        w_ctrl_d.reg_src     = w_reg_src;
        w_ctrl_d.flag_w      = w_flag_w;
        w_ctrl_d.alu_control = w_alu_control;
    end

    // Output register; reset clears the word without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_q <= '0;
        end else begin
            r_ctrl_q <= w_ctrl_d;
        end
    end

    assign PCS        = r_ctrl_q.pcs;
    assign RegW       = r_ctrl_q.reg_w;
    assign MemW       = r_ctrl_q.mem_w;
    assign MemtoReg   = r_ctrl_q.mem_to_reg;
    assign ALUSrc     = r_ctrl_q.alu_src;
    assign NoWrite    = r_ctrl_q.no_write;
    assign ImmSrc     = r_ctrl_q.imm_src;
    assign RegSrc     = r_ctrl_q.reg_src;
    assign FlagW      = r_ctrl_q.flag_w;
    assign ALUControl = r_ctrl_q.alu_control;

endmodule : decoder
`default_nettype wire

// File: tb/tb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder
//  Description : Self-checking bench for decoder: directed instruction cases,
//                reset behaviour and randomized instructions compared against
//                a behavioural instruction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, RegW, MemW, MemtoReg, ALUSrc, NoWrite;
    logic [1:0] ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;

    int n_checks;
    int n_fails;
    logic [14:0] prev_exp;

    decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .NoWrite    (NoWrite),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .FlagW      (FlagW),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs in a fixed order:
    // {PCS,RegW,MemW,MemtoReg,ALUSrc,NoWrite,ImmSrc,RegSrc,FlagW,ALUControl}
    function automatic logic [14:0] observed();
        return {PCS, RegW, MemW, MemtoReg, ALUSrc, NoWrite, ImmSrc, RegSrc, FlagW, ALUControl};
    endfunction

    // Instruction-level reference: what each instruction class needs.
    function automatic logic [14:0] ref_model(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        bit regw = 0, memw = 0, m2r = 0, asrc = 0, nowr = 0, br = 0, dp = 0, pcs;
        bit [1:0] imm = 0, rsrc = 0, fw = 0;
        bit [2:0] aluc = 0;
        int cmd;
        bit s;
        if (op == 2'd0) begin
            dp = 1; regw = 1; asrc = fn[5];
        end else if (op == 2'd1) begin
            asrc = 1; imm = 1;
            if (fn[0]) begin regw = 1; m2r = 1; end
            else begin memw = 1; rsrc = 2; end
        end else if (op == 2'd2) begin
            br = 1; asrc = 1; imm = 2; rsrc = 1;
        end
        if (dp) begin
            cmd = int'(fn[4:1]);
            s   = fn[0];
            if      (cmd == 4)  aluc = 0;
            else if (cmd == 2)  aluc = 1;
            else if (cmd == 0)  aluc = 2;
            else if (cmd == 12) aluc = 3;
            else if (cmd == 1)  aluc = 4;
            else if (cmd == 10) begin aluc = 1; nowr = 1; end
            else                aluc = 0;
            if (cmd == 10) fw = 2'b11;
            else           fw = {s, s && (aluc == 0 || aluc == 1)};
        end
        pcs = (rd == 15 && regw) || br;
        return {pcs, regw, memw, m2r, asrc, nowr, imm, rsrc, fw, aluc};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction at negedge, confirm outputs still hold the prior
    // decode (registered), then confirm the new decode after the next posedge.
    task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        logic [14:0] exp;
        @(negedge clk);
        Op = op; Funct = fn; Rd = rd;
        #1;
        check_eq({tag, "_hold"}, 32'(observed()), 32'(prev_exp));
        exp = ref_model(op, fn, rd);
        @(posedge clk);
        #1;
        check_eq(tag, 32'(observed()), 32'(exp));
        prev_exp = exp;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        prev_exp = '0;
        rst_n = 1'b0;
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;

        // Reset before any clock edge.
        #2;
        check_eq("reset_initial", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        check_eq("reset_held_clk", 32'(observed()), 32'd0);

        // First edge after release registers the current inputs (LDR to PC).
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset_ldr", 32'(observed()), 32'(ref_model(2'b01, 6'b011001, 4'd15)));
        check_eq("post_reset_ldr_pcs", 32'(PCS), 32'd1);
        prev_exp = ref_model(2'b01, 6'b011001, 4'd15);

        // Directed instructions.
        apply("dp_reg_add", 2'b00, 6'b001000, 4'd5);
        check_eq("dp_reg_add_fields", {RegW, ALUSrc, RegSrc, ALUControl, FlagW, PCS, MemW}, {1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0});
        apply("dp_imm_add", 2'b00, 6'b101000, 4'd2);
        check_eq("dp_imm_add_fields", {RegW, ALUSrc, ImmSrc, ALUControl, PCS}, {1'b1, 1'b1, 2'b00, 3'b000, 1'b0});
        apply("str", 2'b01, 6'b011000, 4'd3);
        check_eq("str_fields", {MemW, RegW, ALUSrc, ImmSrc, RegSrc}, {1'b1, 1'b0, 1'b1, 2'b01, 2'b10});
        apply("ldr", 2'b01, 6'b011001, 4'd4);
        check_eq("ldr_fields", {MemtoReg, RegW, ImmSrc}, {1'b1, 1'b1, 2'b01});
        apply("branch_a", 2'b10, 6'b100000, 4'd0);
        check_eq("branch_a_fields", {PCS, RegW, ImmSrc, RegSrc}, {1'b1, 1'b0, 2'b10, 2'b01});
        apply("branch_b", 2'b10, 6'b101111, 4'd15);
        check_eq("branch_b_fields", {PCS, RegW, ImmSrc, RegSrc}, {1'b1, 1'b0, 2'b10, 2'b01});
        apply("cmp_s", 2'b00, 6'b010101, 4'd1);
        check_eq("cmp_s_fields", {ALUControl, NoWrite, FlagW}, {3'b001, 1'b1, 2'b11});
        apply("cmp_nos", 2'b00, 6'b010100, 4'd1);
        check_eq("cmp_nos_flagw", 32'(FlagW), 32'd3);
        apply("and_s", 2'b00, 6'b000001, 4'd7);
        check_eq("and_s_flagw", 32'(FlagW), 32'd2);
        apply("eor", 2'b00, 6'b000010, 4'd7);
        apply("orr_s", 2'b00, 6'b011001, 4'd7);
        apply("sub_s", 2'b00, 6'b000101, 4'd7);
        check_eq("sub_s_flagw", 32'(FlagW), 32'd3);
        apply("undef_cmd", 2'b00, 6'b011111, 4'd7);
        apply("dp_to_pc", 2'b00, 6'b001000, 4'd15);
        check_eq("dp_to_pc_pcs", 32'(PCS), 32'd1);
        apply("unsupported", 2'b11, 6'b111111, 4'd15);
        check_eq("unsupported_zero", 32'(observed()), 32'd0);

        // Load a nonzero decode, then assert reset between edges.
        apply("pre_reset_ldr", 2'b01, 6'b000001, 4'd15);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("reset_async_mid", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        check_eq("reset_mid_held", 32'(observed()), 32'd0);
        @(negedge clk);
        Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
        rst_n = 1'b1;
        #1;
        check_eq("reset_release_no_residue", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        check_eq("post_reset_branch", 32'(observed()), 32'(ref_model(2'b10, 6'b000000, 4'd0)));
        prev_exp = ref_model(2'b10, 6'b000000, 4'd0);

        // Randomized instructions; half the DP ops use a recognised cmd.
        for (int i = 0; i < 300; i++) begin
            logic [1:0] rop;
            logic [5:0] rfn;
            logic [3:0] rrd;
            logic [3:0] cmds [6];
            cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd2;
            cmds[3] = 4'd4; cmds[4] = 4'd10; cmds[5] = 4'd12;
            rop = 2'($urandom_range(0, 3));
            rfn = 6'($urandom);
            rrd = 4'($urandom);
            if ($urandom_range(0, 1) == 1) rfn[4:1] = cmds[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rrd = 4'd15;
            apply("random", rop, rfn, rrd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // Absolute bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_decoder
`default_nettype wire

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Op  input  2  instruction bits [27:26].
REQ-005 Funct  input  6  instruction bits [25:20]: Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S/L.
REQ-006 Rd  input  4  instruction bits [15:12].
REQ-007 PCS  output  1  PC source: write PC from result.
REQ-008 RegW, MemW, MemtoReg, ALUSrc, NoWrite  output  1 each  register write, memory write, load-result select, immediate ALU operand, CMP result suppression.
REQ-009 ImmSrc  output  2  extend select: 00 = imm8 DP, 01 = imm12 memory, 10 = imm24 branch.
REQ-010 RegSrc  output  2  bit1 = read Rd as second source (store), bit0 = read R15 as first source (branch).
REQ-011 FlagW  output  2  bit1 = write NZ flags, bit0 = write CV flags.
REQ-012 ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.

Function
REQ-013 The decode logic SHALL be combinational; all outputs SHALL be registered on the rising edge of clk, with 1-cycle latency from input change to output.
REQ-014 Op=00, Funct[5]=0 (DP register): RegW=1, ALUSrc=0, ImmSrc=00, RegSrc=00, MemW=0, MemtoReg=0, ALUOp=1.
REQ-015 Op=00, Funct[5]=1 (DP immediate): same as REQ-014 except ALUSrc=1.
REQ-016 Op=01, Funct[0]=0 (STR): MemW=1, RegW=0, ALUSrc=1, ImmSrc=01, RegSrc=10, MemtoReg=0, ALUOp=0.
REQ-017 Op=01, Funct[0]=1 (LDR): MemtoReg=1, RegW=1, MemW=0, ALUSrc=1, ImmSrc=01, RegSrc=00, ALUOp=0.
REQ-018 Op=10 (B): internal Branch=1, RegW=0, MemW=0, MemtoReg=0, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUOp=0; Funct bits are ignored.
REQ-019 Op=11 (unsupported): all outputs 0.
REQ-020 Condition-field handling is out of scope: conditional branches decode identically to B.
REQ-021 With ALUOp=1, cmd SHALL decode to ALUControl as follows: 0100 ADD->000, 0010 SUB->001, 0000 AND->010, 1100 ORR->011, 0001 EOR->100, 1010 CMP->001 with NoWrite=1; any other cmd->000.
REQ-022 With ALUOp=1: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] AND (ALUControl is 000 or 001).
REQ-023 With ALUOp=1 and cmd=CMP: FlagW=11 regardless of S.
REQ-024 With ALUOp=0: ALUControl=000, FlagW=00, NoWrite=0.
REQ-025 PCS=(Rd==15 AND RegW) OR Branch, evaluated on the decoded (pre-register) values.
REQ-026 Every don't-care output SHALL be driven to 0; no X shall be propagated.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-028 After rst_n deasserts, the first rising clk edge SHALL register the decode of the current inputs.
REQ-029 Reset asserted mid-operation SHALL discard the pending decode with no residual state.

Structure
REQ-030 A shared package decoder_pkg SHALL hold the Op encodings, ALUControl encodings, ImmSrc encodings and cmd constants.
REQ-031 The ALU/flag decode (REQ-021 to REQ-024) SHALL be one sub-module, alu_dec; the main decode, PCS logic and output registers SHALL reside in decoder.

Verification
REQ-032 Op=00, Funct=001000, Rd=5 -> next cycle RegW=1, ALUSrc=0, RegSrc=00, ALUControl=000, FlagW=00, PCS=0, MemW=0.
REQ-033 Op=00, Funct=101000, Rd=2 -> RegW=1, ALUSrc=1, ImmSrc=00, ALUControl=000, PCS=0.
REQ-034 Op=01, Funct=011000 (STR) -> MemW=1, RegW=0, ALUSrc=1, ImmSrc=01, RegSrc=10.
REQ-035 Op=01, Funct=011001 (LDR) -> MemtoReg=1, RegW=1, ImmSrc=01.
REQ-036 Op=10 with Funct=100000, Rd=0 and with Funct=101111, Rd=15 -> both PCS=1, RegW=0, ImmSrc=10, RegSrc=01.
REQ-037 rst_n low between clock edges -> all outputs 0 at once; Op=00, Funct=010101 (CMP, S=1) -> ALUControl=001, NoWrite=1, FlagW=11.
